// File: rtl/accum_pkg.sv
// Shared state encoding and default sizing for the SRAM stream reader.
package accum_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam int unsigned DEF_SRAM_DEPTH = 1024;
  localparam int unsigned DEF_DATA_WIDTH = 32;
  localparam int unsigned DEF_FIFO_DEPTH = 4;

endpackage

// File: rtl/sram_rd_fifo.sv
// Small synchronous FIFO buffering SRAM read data toward the output stream.
module sram_rd_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned DW    = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [DW-1:0]          din,
  input  logic                   pop,
  output logic [DW-1:0]          dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [DW-1:0] r_mem [DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          w_push;
  logic          w_pop;

  assign full   = (r_count == CW'(DEPTH));
  assign empty  = (r_count == '0);
  assign count  = r_count;
  assign w_push = push && !full;
  assign w_pop  = pop && !empty;
  // Head is forced to zero when empty so the stream data bus is clean after reset.
  assign dout   = empty ? '0 : r_mem[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= din;
  end

endmodule

// File: rtl/sram_stream_reader.sv
// Streams a contiguous, wrapping range of SRAM words out through a valid/ready
// interface, issuing reads only when the output buffer has room for them.
module sram_stream_reader
  import accum_pkg::*;
#(
  parameter int unsigned SRAM_DEPTH = DEF_SRAM_DEPTH,
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic [$clog2(SRAM_DEPTH)-1:0] base_addr,
  input  logic [$clog2(SRAM_DEPTH):0]   len,
  output logic                          busy,
  output logic                          done,
  output logic                          enb,
  output logic [$clog2(SRAM_DEPTH)-1:0] addrb,
  input  logic [DATA_WIDTH-1:0]         dob,
  output logic                          m_valid,
  input  logic                          m_ready,
  output logic [DATA_WIDTH-1:0]         m_data,
  output logic                          m_last
);

  localparam int unsigned AW = $clog2(SRAM_DEPTH);
  localparam int unsigned LW = AW + 1;
  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

  state_t          r_state;
  logic [AW-1:0]   r_addr;
  logic [LW-1:0]   r_len;
  logic [LW-1:0]   r_issued;
  logic [LW-1:0]   r_delivered;
  logic            r_pending;
  logic            r_done;

  logic            w_enb;
  logic            w_pop;
  logic            w_last;
  logic            w_full;
  logic            w_empty;
  logic [CW-1:0]   w_fifo_count;
  logic [DATA_WIDTH-1:0] w_head;

  // Credit check counts the read still in flight; a pop this cycle is not credited.
  assign w_enb = (r_state == READ) && (r_issued < r_len) && !w_full &&
                 ((w_fifo_count + CW'(r_pending)) < CW'(FIFO_DEPTH));
  assign w_pop  = m_valid && m_ready;
  assign w_last = m_valid && (r_state != IDLE) && (r_delivered == r_len - LW'(1));

  assign busy    = (r_state != IDLE);
  assign done    = r_done;
  assign enb     = w_enb;
  assign addrb   = r_addr;
  assign m_valid = !w_empty;
  assign m_data  = w_head;
  assign m_last  = w_last;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_addr      <= '0;
      r_len       <= '0;
      r_issued    <= '0;
      r_delivered <= '0;
      r_pending   <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_done    <= 1'b0;
      r_pending <= w_enb;
      if (w_pop) r_delivered <= r_delivered + LW'(1);
      case (r_state)
        IDLE: begin
          if (start) begin
            if (len == '0) begin
              r_done <= 1'b1;
            end else begin
              r_len       <= len;
              r_addr      <= base_addr;
              r_issued    <= '0;
              r_delivered <= '0;
              r_state     <= READ;
            end
          end
        end
        READ: begin
          if (w_enb) begin
            r_issued <= r_issued + LW'(1);
            r_addr   <= (r_addr == AW'(SRAM_DEPTH - 1)) ? '0 : r_addr + AW'(1);
            if (r_issued == r_len - LW'(1)) r_state <= DRAIN;
          end
        end
        DRAIN: begin
          if (w_pop && w_last) begin
            r_state <= IDLE;
            r_done  <= 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  sram_rd_fifo #(
    .DEPTH (FIFO_DEPTH),
    .DW    (DATA_WIDTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (r_pending),
    .din   (dob),
    .pop   (w_pop),
    .dout  (w_head),
    .full  (w_full),
    .empty (w_empty),
    .count (w_fifo_count)
  );

endmodule

// File: tb/tb_sram_stream_reader.sv
// Randomized scoreboard bench for sram_stream_reader with a transaction-level
// reference model of issue credit, delivery order and completion.
module tb_sram_stream_reader;

  localparam int unsigned DEPTH = 1024;
  localparam int unsigned DW    = 32;
  localparam int unsigned FD    = 4;
  localparam int unsigned AW    = 10;
  localparam int unsigned LW    = 11;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [LW-1:0] len = '0;
  logic          busy, done, enb, m_valid, m_last;
  logic [AW-1:0] addrb;
  logic [DW-1:0] dob = '0;
  logic [DW-1:0] m_data;
  logic          m_ready = 1'b1;

  always #5 clk = ~clk;

  sram_stream_reader #(
    .SRAM_DEPTH (DEPTH),
    .DATA_WIDTH (DW),
    .FIFO_DEPTH (FD)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .base_addr (base_addr),
    .len       (len),
    .busy      (busy),
    .done      (done),
    .enb       (enb),
    .addrb     (addrb),
    .dob       (dob),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_data    (m_data),
    .m_last    (m_last)
  );

  // SRAM model: one-cycle read latency.
  logic [DW-1:0] mem [DEPTH];
  initial for (int i = 0; i < int'(DEPTH); i++) mem[i] = DW'(i);
  always @(posedge clk) if (enb) dob <= mem[addrb];

  typedef struct {
    logic [DW-1:0] data;
    logic          last;
  } exp_t;
  exp_t exp_q[$];

  int n_tests = 0;
  int n_fail  = 0;

  function automatic void chk(string name, longint unsigned act, longint unsigned exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // Transfer-level model state (updated once per clock edge, at the preceding negedge).
  bit mon_en = 1'b0;
  bit m_busy = 1'b0;
  int m_len  = 0;
  int m_base = 0;
  int n_iss  = 0;
  int n_pop  = 0;
  bit e_prev = 1'b0;
  bit exp_done_next = 1'b0;
  int ready_mode = 0;

  bit ev, evalid, hs, was_busy, nd;
  int vis;

  always @(negedge clk) begin
    if (mon_en) begin
      was_busy = m_busy;
      ev       = m_busy && (n_iss < m_len) && ((n_iss - n_pop) < int'(FD));
      vis      = n_iss - int'(e_prev) - n_pop;
      evalid   = m_busy && (vis > 0);
      chk("busy", busy, was_busy);
      chk("enb", enb, ev);
      if (ev) chk("addrb", addrb, (m_base + n_iss) % int'(DEPTH));
      chk("m_valid", m_valid, evalid);
      chk("done", done, exp_done_next);
      hs = evalid && m_ready;
      if (evalid) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL m_data: got %0h, no word expected (t=%0t)", m_data, $time);
        end else begin
          chk("m_data", m_data, exp_q[0].data);
          chk("m_last", m_last, exp_q[0].last);
          if (hs) void'(exp_q.pop_front());
        end
      end else begin
        chk("m_last_idle", m_last, 0);
      end
      nd = 1'b0;
      if (rst) begin
        m_busy = 1'b0;
        n_iss  = 0;
        n_pop  = 0;
        e_prev = 1'b0;
        exp_q.delete();
      end else begin
        if (hs) begin
          n_pop++;
          if (n_pop == m_len) begin
            m_busy = 1'b0;
            nd     = 1'b1;
          end
        end
        if (ev) n_iss++;
        e_prev = ev;
        if (!was_busy && start) begin
          if (len == '0) begin
            nd = 1'b1;
          end else begin
            m_busy = 1'b1;
            m_len  = int'(len);
            m_base = int'(base_addr);
            n_iss  = 0;
            n_pop  = 0;
            e_prev = 1'b0;
          end
        end
      end
      exp_done_next = nd;
    end
  end

  // m_ready driver: 0 = always ready, 1 = 1-0-0-1 pattern, 2 = random.
  initial begin
    int ph;
    ph = 0;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0: m_ready = 1'b1;
        1: begin
          m_ready = (ph == 0) || (ph == 3);
          ph = (ph + 1) % 4;
        end
        default: m_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  task automatic start_xfer(input int b, input int l);
    exp_t e;
    @(posedge clk);
    #1;
    start     = 1'b1;
    base_addr = AW'(b);
    len       = LW'(l);
    for (int k = 0; k < l; k++) begin
      e.data = mem[(b + k) % int'(DEPTH)];
      e.last = (k == l - 1);
      exp_q.push_back(e);
    end
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic check_reset_outputs();
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_enb", enb, 0);
    chk("rst_addrb", addrb, 0);
    chk("rst_m_valid", m_valid, 0);
    chk("rst_m_last", m_last, 0);
    chk("rst_m_data", m_data, 0);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic wait_idle();
    int c;
    c = 0;
    while ((m_busy || exp_done_next) && c < 4000) begin
      @(posedge clk);
      c++;
    end
    if (m_busy) begin
      n_tests++;
      n_fail++;
      $display("FAIL timeout: transfer still active after %0d cycles, expected completion", c);
      do_reset();
    end
    repeat (2) @(posedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int c, b, l;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    mon_en = 1'b1;
    check_reset_outputs();

    ready_mode = 0;
    start_xfer(10, 4);
    wait_idle();
    start_xfer(1022, 4);
    wait_idle();
    start_xfer(5, 0);
    wait_idle();

    ready_mode = 1;
    start_xfer(100, 16);
    wait_idle();

    // Reset in the middle of a transfer, then a fresh short transfer.
    ready_mode = 0;
    start_xfer(200, 8);
    c = 0;
    while (n_pop < 3 && c < 200) begin
      @(posedge clk);
      c++;
    end
    chk("mid_xfer_words", n_pop, 3);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    check_reset_outputs();
    start_xfer(0, 2);
    wait_idle();

    // Start pulse while busy must be ignored.
    ready_mode = 1;
    start_xfer(300, 6);
    repeat (2) @(posedge clk);
    #1;
    start     = 1'b1;
    base_addr = '0;
    len       = LW'(3);
    @(posedge clk);
    #1 start = 1'b0;
    wait_idle();

    ready_mode = 0;
    start_xfer(512, 1024);
    wait_idle();

    for (int it = 0; it < 25; it++) begin
      ready_mode = int'($urandom_range(0, 2));
      b = int'($urandom_range(0, DEPTH - 1));
      l = int'($urandom_range(0, 40));
      start_xfer(b, l);
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(0, 3)) @(posedge clk);
        #1;
        if (m_busy) begin
          start     = 1'b1;
          base_addr = AW'($urandom_range(0, DEPTH - 1));
          len       = LW'($urandom_range(1, 8));
          @(posedge clk);
          #1 start = 1'b0;
        end
      end
      wait_idle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sram_stream_reader.md
SRAM_STREAM_READER -- requirements
Module: sram_stream_reader

Interface
REQ-001 SHALL have parameter SRAM_DEPTH, default 1024, meaning the number of SRAM words addressed.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, meaning the SRAM word and stream data width.
REQ-003 SHALL have parameter FIFO_DEPTH, default 4, meaning the number of output buffer entries (power of 2, at least 4).
REQ-004 SHALL use one clock and a synchronous, active-high reset.
REQ-005 clk  in  1  sole clock; all logic on posedge.
REQ-006 rst  in  1  synchronous active-high reset.
REQ-007 start  in  1  command strobe; accepted only in IDLE.
REQ-008 base_addr  in  $clog2(SRAM_DEPTH)  first word address, sampled on start.
REQ-009 len  in  $clog2(SRAM_DEPTH)+1  word count, sampled on start; range 0..SRAM_DEPTH.
REQ-010 busy  out  1  high whenever state != IDLE.
REQ-011 done  out  1  one-cycle completion pulse.
REQ-012 enb  out  1  SRAM read-port enable.
REQ-013 addrb  out  $clog2(SRAM_DEPTH)  SRAM read address.
REQ-014 dob  in  DATA_WIDTH  SRAM read data, valid on the cycle after the enb cycle.
REQ-015 m_valid / m_ready / m_data / m_last  out/in/out/out  1/1/DATA_WIDTH/1  output stream; m_last marks the final word.

Function
REQ-016 States SHALL be IDLE, READ and DRAIN.
REQ-017 IDLE with start=1 and len>0: latch base_addr and len, go to READ; with len=0: no reads, done=1 on the next cycle, stay IDLE.
REQ-018 In READ, enb SHALL be 1 only when issued_count < len and fifo_count + pending < FIFO_DEPTH (a same-cycle pop is not credited).
REQ-019 addrb SHALL equal base_addr for the first issue and increment by 1 after each issue, wrapping from SRAM_DEPTH-1 to 0.
REQ-020 pending SHALL be registered as enb; when pending=1, dob SHALL be pushed into the FIFO that cycle.
REQ-021 READ SHALL go to DRAIN in the cycle after the len-th issue.
REQ-022 DRAIN SHALL go to IDLE on the handshake (m_valid & m_ready) of the word with m_last=1; done SHALL be 1 on the following cycle only.
REQ-023 m_valid SHALL equal fifo_count != 0; m_data SHALL be the FIFO head; m_data SHALL stay stable while m_valid=1 and m_ready=0.
REQ-024 m_last SHALL be 1 only with the len-th word delivered.
REQ-025 Latency: start at edge E0 gives enb=1 in cycle 1 and m_valid=1 in cycle 3.
REQ-026 Throughput: with m_ready held 1, one word per cycle after fill.
REQ-027 start while busy=1 SHALL be ignored.
REQ-028 Simultaneous push and pop SHALL leave fifo_count unchanged.
REQ-029 Words SHALL be delivered in address order with none lost or duplicated under arbitrary m_ready.

Reset
REQ-030 rst=1 SHALL return the block to IDLE at any time, including mid-transfer.
REQ-031 Reset SHALL clear the FIFO, pending and all counters.
REQ-032 After reset: busy=0, done=0, enb=0, addrb=0, m_valid=0, m_last=0, m_data=0.
REQ-033 Reset SHALL discard any in-flight SRAM read.

Structure
REQ-034 A shared package accum_pkg SHALL hold the state enum (IDLE, READ, DRAIN) and the default-width constants.
REQ-035 The output buffer SHALL be a sub-module, sram_rd_fifo: synchronous FIFO with push, pop, full, empty and count.
REQ-036 The FSM, address counter and credit logic SHALL reside in sram_stream_reader.

Verification
REQ-037 Preload mem[i]=i; base=10, len=4, m_ready=1 -> m_data 10,11,12,13 on consecutive cycles, m_last on 13, done one cycle later.
REQ-038 base=1022, len=4 -> addrb 1022,1023,0,1; data in that order.
REQ-039 len=0 -> enb never asserted, done pulse on the next cycle, busy stays 0.
REQ-040 len=16 with m_ready toggled 1-0-0-1 -> all 16 words in order; enb stalls when fifo_count + pending = 4; m_data stable during stalls.
REQ-041 rst asserted after the 3rd word of len=8 -> next cycle IDLE with all outputs 0; a new start (base=0, len=2) yields words 0 and 1 only.
REQ-042 start pulsed during busy -> ignored; the original transfer completes unchanged.
